cascade_cmp_seq: RTL

- Sequencer that compares two multi-byte operands by driving an external 8-bit magnitude comparator one byte per cycle, MSB byte first.
- It consumes that comparator's less/equal/greater flags and stops early at the first unequal byte.
- Sits directly around the 8-bit comparator: it feeds the comparator's A/B byte inputs and receives its ALBO/AEBO/AGBO outputs.
- Delivers a registered wide-compare result with a start/done handshake to the CPU branch/ALU logic.

---
 rtl/cascade_cmp_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/cascade_cmp_seq.sv
// Multi-byte magnitude compare sequencer driving an external 8-bit comparator MSB byte first.
// Optional build macro SIGNED_CMP_EN selects two's-complement compare (MSB-byte sign bits inverted).
module cascade_cmp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  ready,
    output logic                  done,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt,
    output logic                  err,
    output logic [3:0]            bytes_used,
    output logic [7:0]            cmp_a,
    output logic [7:0]            cmp_b,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt
);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    localparam logic [2:0] IDX_MSB = 3'(NBYTES - 1);

    state_t              state, state_nxt;
    logic [8*NBYTES-1:0] a_q, b_q;
    logic [2:0]          idx;
    logic [2:0]          flags;
    logic [7:0]          byte_a, byte_b;

    assign flags  = {cmp_lt, cmp_eq, cmp_gt};
    assign byte_a = a_q[{idx, 3'b000} +: 8];
    assign byte_b = b_q[{idx, 3'b000} +: 8];

`ifdef SIGNED_CMP_EN
    logic [7:0] msb_flip;
    // Offset-binary: flipping both sign bits turns a signed compare into an unsigned one.
    assign msb_flip = (idx == IDX_MSB) ? 8'h80 : 8'h00;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        cmp_a     = 8'h00;
        cmp_b     = 8'h00;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = CMP;
            end
            CMP: begin
`ifdef SIGNED_CMP_EN
                cmp_a = byte_a ^ msb_flip;
                cmp_b = byte_b ^ msb_flip;
`else
                cmp_a = byte_a;
                cmp_b = byte_b;
`endif
                if (flags != 3'b010 || idx == 3'd0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: operand registers are reset too, so cmp_a/cmp_b and results are clean right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            lt         <= 1'b0;
            eq         <= 1'b0;
            gt         <= 1'b0;
            err        <= 1'b0;
            bytes_used <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= op_a;
                        b_q <= op_b;
                        idx <= IDX_MSB;
                        lt  <= 1'b0;
                        eq  <= 1'b0;
                        gt  <= 1'b0;
                        err <= 1'b0;
                    end
                end
                CMP: begin
                    if (state_nxt == DONE) bytes_used <= 4'(NBYTES) - {1'b0, idx};
                    case (flags)
                        3'b100:  lt <= 1'b1;
                        3'b001:  gt <= 1'b1;
                        3'b010: begin
                            if (idx == 3'd0) eq <= 1'b1;
                            else             idx <= idx - 3'd1;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
